// File: rtl/ooo_decode_dispatch_queue.sv
// Decode-to-issue dispatch FIFO: in-order, flushable, optional empty bypass.
// Explicit pointer wrap so any DEPTH >= 2 works.
module ooo_decode_dispatch_queue #(
  parameter int PKT_W  = 64,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 0
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       flush,
  input  logic                       dec_valid,
  output logic                       dec_ready,
  input  logic [PKT_W-1:0]           dec_packet,
  output logic                       ex_valid,
  input  logic                       ex_ready,
  output logic [PKT_W-1:0]           ex_packet,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             enq;
  logic             deq;
  logic             byp;
  logic             head_valid;
  logic             wr;
  logic             rd;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign dec_ready  = !full && !flush;
  assign head_valid = !empty && !flush;
  assign byp        = (BYPASS != 0) && empty
                      && dec_valid && !flush;
  assign ex_valid   = head_valid || byp;

  always_comb begin
    ex_packet = '0;
    if (head_valid) ex_packet = mem[rd_ptr];
    else if (byp)   ex_packet = dec_packet;
  end

  assign enq = dec_valid && dec_ready;
  assign deq = ex_valid && ex_ready;
  // A bypassed bundle consumed this cycle never lands in storage.
  assign wr  = enq && !(byp && ex_ready);
  assign rd  = deq && head_valid;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge CLK) begin
    if (wr) mem[wr_ptr] <= dec_packet;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= nxt(wr_ptr);
      if (rd) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(wr) - CW'(rd);
    end
  end

  a_cnt: assert property (@(posedge CLK)
    disable iff (!nRST) count <= CW'(DEPTH));
  a_ovf: assert property (@(posedge CLK)
    disable iff (!nRST) !(enq && full));
  a_unf: assert property (@(posedge CLK)
    disable iff (!nRST) !(deq && empty && !byp));

endmodule
